// File: rtl/game_pkg.sv
// Shared types and constants for the game-to-UART status link.
// Frame layout on the wire: SYNC, TAG = {slot, seq}, PAY, CHK = SYNC ^ TAG ^ PAY.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND_SYNC,
    SEND_TAG,
    SEND_PAY,
    SEND_CHK
  } tx_frame_state;

  typedef enum logic [1:0] {
    SLOT_STATE,
    SLOT_GLOVES,
    SLOT_MOUSE,
    SLOT_SCORE
  } uart_slot;

  localparam logic [7:0] UART_SYNC = 8'hA5;
  localparam int         NUM_SLOTS = 4;

  function automatic logic [7:0] frame_checksum(input logic [7:0] sync,
                                                input logic [7:0] tag,
                                                input logic [7:0] pay);
    return sync ^ tag ^ pay;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker over four request lines.
// Search starts at ptr; the pointer register is owned by the parent.
module uart_rr_arbiter
  import game_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frames the four game status bytes into SYNC/TAG/PAY/CHK packets for the UART tx FIFO,
// resending a slot when its byte changes or on every periodic refresh.
module uart_frame_tx
  import game_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = UART_SYNC,
  parameter int         REFRESH_CYCLES = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_game_state_sel,
  input  logic [7:0] data_gloves_control,
  input  logic [7:0] data_mouse_control,
  input  logic [7:0] data_score_control,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic       frame_busy
);

  localparam int               CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  tx_frame_state    state, state_next;
  logic [5:0]       seq;
  logic [CNT_W-1:0] refresh_cnt;
  logic             refresh_tick;
  logic [7:0]       last_sent [NUM_SLOTS];
  logic [1:0]       rr_ptr;
  logic [3:0]       pending, pending_next, set_req;
  logic [7:0]       slot_data [NUM_SLOTS];

  logic             grant_valid;
  logic [1:0]       grant_idx;
  uart_slot         grant_slot;
  logic [7:0]       latch_pay, latch_tag;
  logic [7:0]       frame_tag, frame_pay, frame_chk;

  assign slot_data[0] = data_game_state_sel;
  assign slot_data[1] = data_gloves_control;
  assign slot_data[2] = data_mouse_control;
  assign slot_data[3] = data_score_control;

  uart_rr_arbiter u_arbiter (
    .req         (pending),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign refresh_tick = (refresh_cnt == CNT_LAST);
  assign grant_slot   = uart_slot'(grant_idx);
  assign latch_pay    = slot_data[grant_idx];
  assign latch_tag    = {grant_slot, seq};

  always_comb begin
    set_req = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      set_req[i] = (slot_data[i] != last_sent[i]) || refresh_tick;
    end
  end

  // The slot being latched stays pending only if its input already differs from the captured byte.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state == LATCH && grant_idx == 2'(i)) begin
        pending_next[i] = set_req[i] && (slot_data[i] != latch_pay);
      end else begin
        pending_next[i] = pending[i] || set_req[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    wr_uart    = 1'b0;
    w_data     = 8'h00;
    frame_busy = (state != IDLE);
    case (state)
      IDLE:  if (pending != 4'b0000) state_next = LATCH;
      LATCH: state_next = grant_valid ? SEND_SYNC : IDLE;
      SEND_SYNC: if (!tx_full) begin
        wr_uart    = 1'b1;
        w_data     = SYNC_BYTE;
        state_next = SEND_TAG;
      end
      SEND_TAG: if (!tx_full) begin
        wr_uart    = 1'b1;
        w_data     = frame_tag;
        state_next = SEND_PAY;
      end
      SEND_PAY: if (!tx_full) begin
        wr_uart    = 1'b1;
        w_data     = frame_pay;
        state_next = SEND_CHK;
      end
      SEND_CHK: if (!tx_full) begin
        wr_uart    = 1'b1;
        w_data     = frame_chk;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      seq         <= '0;
      refresh_cnt <= '0;
      rr_ptr      <= '0;
      pending     <= 4'b1111;
      frame_tag   <= '0;
      frame_pay   <= '0;
      frame_chk   <= '0;
      // NOTE: this tiny register array is reset because the post-reset dump compares against zero.
      for (int i = 0; i < NUM_SLOTS; i++) last_sent[i] <= '0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      refresh_cnt <= refresh_tick ? '0 : refresh_cnt + 1'b1;
      if (state == LATCH) begin
        frame_tag            <= latch_tag;
        frame_pay            <= latch_pay;
        frame_chk            <= frame_checksum(SYNC_BYTE, latch_tag, latch_pay);
        last_sent[grant_idx] <= latch_pay;
        rr_ptr               <= grant_idx + 2'd1;
      end
      if (state == SEND_CHK && !tx_full) seq <= seq + 6'd1;
    end
  end

endmodule
